// File: rtl/riscv_mem_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package riscv_mem_pkg;

   // Default address/data width of the core's memory interface.
   localparam int DEF_XLEN = 32;

   // Arbiter sequencing: arbitrate, hold a request until granted, await the response.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } arb_state_t;

   // Which requester owns the transaction currently on the memory port.
   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_INSTR = 2'd1,
      OWN_DATA  = 2'd2
   } owner_t;

   // Request fields latched at arbitration and presented on the mem_* outputs.
   typedef struct packed {
      logic [DEF_XLEN-1:0]   addr;
      logic                  we;
      logic [DEF_XLEN-1:0]   wdata;
      logic [DEF_XLEN/8-1:0] wstrb;
   } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and load/store requests,
// plus the starvation counter value that follows the decision.
module mem_arb_pick
   import riscv_mem_pkg::*;
#(
   parameter int STARVE_LIMIT = 2,
   parameter int CW           = $clog2(STARVE_LIMIT + 1)
) (
   input  logic          instr_valid,
   input  logic          data_valid,
   input  logic [CW-1:0] starve_cnt,
   output logic          pick_instr,
   output logic          pick_data,
   output logic [CW-1:0] starve_cnt_next
);

   // Data wins by default; a waiting fetch wins once it has been passed over STARVE_LIMIT times.
   always_comb begin
      pick_instr      = 1'b0;
      pick_data       = 1'b0;
      starve_cnt_next = '0;
      if (instr_valid && (!data_valid || (starve_cnt == CW'(STARVE_LIMIT)))) begin
         pick_instr = 1'b1;
      end else if (data_valid) begin
         pick_data = 1'b1;
         if (instr_valid) begin
            starve_cnt_next = (starve_cnt == CW'(STARVE_LIMIT)) ? starve_cnt
                                                                : starve_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Each transaction runs request (mem_req until mem_gnt, owner's ack pulses on
// the grant) then response (owner's ready pulses on mem_rvalid). Only one
// transaction is outstanding; the response cycle re-arbitrates so
// back-to-back requests go straight to the next request phase.
// The mem_req_t fields are sized by DEF_XLEN, so XLEN must equal DEF_XLEN.
module mem_port_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int XLEN         = DEF_XLEN,
   parameter int STARVE_LIMIT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instruction_valid,
   input  logic [XLEN-1:0]   instruction_addr,
   output logic              instruction_ack,
   output logic              instruction_ready,
   output logic [XLEN-1:0]   instruction_read,
   input  logic              data_read_valid,
   input  logic              data_write_valid,
   input  logic [XLEN-1:0]   data_addr,
   input  logic [XLEN-1:0]   data_write,
   input  logic [XLEN/8-1:0] data_write_byte,
   output logic              data_ack,
   output logic              data_ready,
   output logic [XLEN-1:0]   data_read,
   output logic              mem_req,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wstrb,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   arb_state_t      state, state_n;
   owner_t          owner, owner_n;
   logic [CW-1:0]   starve_cnt, starve_cnt_n, pick_cnt;
   mem_req_t        req_q, req_n;
   logic [XLEN-1:0] iread_q, dread_q;
   logic            data_valid, pick_instr, pick_data, resp, arbitrate;

   assign data_valid = data_read_valid | data_write_valid;

   mem_arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CW           (CW)
   ) u_pick (
      .instr_valid     (instruction_valid),
      .data_valid      (data_valid),
      .starve_cnt      (starve_cnt),
      .pick_instr      (pick_instr),
      .pick_data       (pick_data),
      .starve_cnt_next (pick_cnt)
   );

   // mem_rvalid only counts while a response is awaited; elsewhere it is stale.
   assign resp      = (state == WAIT) && mem_rvalid;
   assign arbitrate = (state == IDLE) || resp;

   assign mem_req   = (state == REQ);
   assign mem_we    = req_q.we;
   assign mem_addr  = req_q.addr;
   assign mem_wdata = req_q.wdata;
   assign mem_wstrb = req_q.wstrb;

   assign instruction_ack   = mem_req && mem_gnt && (owner == OWN_INSTR);
   assign data_ack          = mem_req && mem_gnt && (owner == OWN_DATA);
   assign instruction_ready = resp && (owner == OWN_INSTR);
   assign data_ready        = resp && (owner == OWN_DATA);
   assign instruction_read  = instruction_ready ? mem_rdata : iread_q;
   assign data_read         = data_ready ? mem_rdata : dread_q;

   // Next state, owner, starvation count and latched request fields.
   always_comb begin
      state_n      = state;
      owner_n      = owner;
      starve_cnt_n = starve_cnt;
      req_n        = req_q;
      if ((state == REQ) && mem_gnt) begin
         state_n = WAIT;
      end else if (arbitrate) begin
         starve_cnt_n = pick_cnt;
         if (pick_instr) begin
            state_n     = REQ;
            owner_n     = OWN_INSTR;
            req_n.addr  = instruction_addr;
            req_n.we    = 1'b0;
            req_n.wdata = '0;
            req_n.wstrb = '0;
         end else if (pick_data) begin
            // A simultaneous read and write request is taken as a write.
            state_n     = REQ;
            owner_n     = OWN_DATA;
            req_n.addr  = data_addr;
            req_n.we    = data_write_valid;
            req_n.wdata = data_write;
            req_n.wstrb = data_write_byte;
         end else begin
            state_n = IDLE;
            owner_n = OWN_NONE;
         end
      end
   end

   // Control and request registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= OWN_NONE;
         starve_cnt <= '0;
         req_q      <= '0;
      end else begin
         state      <= state_n;
         owner      <= owner_n;
         starve_cnt <= starve_cnt_n;
         req_q      <= req_n;
      end
   end

   // Read outputs hold the last word delivered to each requester.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iread_q <= '0;
         dread_q <= '0;
      end else begin
         if (instruction_ready) iread_q <= mem_rdata;
         if (data_ready)        dread_q <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int LIMIT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instruction_valid = 1'b0;
   logic [31:0] instruction_addr = '0;
   logic        instruction_ack, instruction_ready;
   logic [31:0] instruction_read;
   logic        data_read_valid = 1'b0;
   logic        data_write_valid = 1'b0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_write = '0;
   logic [3:0]  data_write_byte = '0;
   logic        data_ack, data_ready;
   logic [31:0] data_read;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   int errors = 0;
   int checks = 0;

   // Expected grant owners (1 = fetch, 2 = data) while tracking is on.
   logic [1:0] exp_q[$];
   bit         track = 1'b0;

   mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk               (clk),
      .reset             (reset),
      .instruction_valid (instruction_valid),
      .instruction_addr  (instruction_addr),
      .instruction_ack   (instruction_ack),
      .instruction_ready (instruction_ready),
      .instruction_read  (instruction_read),
      .data_read_valid   (data_read_valid),
      .data_write_valid  (data_write_valid),
      .data_addr         (data_addr),
      .data_write        (data_write),
      .data_write_byte   (data_write_byte),
      .data_ack          (data_ack),
      .data_ready        (data_ready),
      .data_read         (data_read),
      .mem_req           (mem_req),
      .mem_we            (mem_we),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_wstrb         (mem_wstrb),
      .mem_gnt           (mem_gnt),
      .mem_rvalid        (mem_rvalid),
      .mem_rdata         (mem_rdata)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: one outstanding transaction, described as
   // "busy / granted yet / who owns it" plus a run of passed-over fetches.
   bit          m_busy = 0;
   bit          m_gnted = 0;
   int          m_owner = 0;
   logic [31:0] m_addr = '0;
   logic        m_we = 1'b0;
   logic [31:0] m_wdata = '0;
   logic [3:0]  m_wstrb = '0;
   int          m_run = 0;
   logic [31:0] m_iread = '0;
   logic [31:0] m_dread = '0;

   always @(posedge clk or posedge reset) begin
      bit resp_now;
      bit dreq;
      if (reset) begin
         m_busy = 0; m_gnted = 0; m_owner = 0; m_run = 0;
         m_addr = '0; m_we = 1'b0; m_wdata = '0; m_wstrb = '0;
         m_iread = '0; m_dread = '0;
      end else begin
         resp_now = m_busy && m_gnted && mem_rvalid;
         if (resp_now && m_owner == 1) m_iread = mem_rdata;
         if (resp_now && m_owner == 2) m_dread = mem_rdata;
         if (m_busy && !m_gnted) begin
            if (mem_gnt) m_gnted = 1;
         end else if (!m_busy || resp_now) begin
            dreq = data_read_valid || data_write_valid;
            if (instruction_valid && (!dreq || m_run == LIMIT)) begin
               m_busy = 1; m_gnted = 0; m_owner = 1; m_run = 0;
               m_addr = instruction_addr; m_we = 1'b0; m_wdata = '0; m_wstrb = '0;
            end else if (dreq) begin
               m_busy = 1; m_gnted = 0; m_owner = 2;
               m_run = instruction_valid ? ((m_run < LIMIT) ? m_run + 1 : LIMIT) : 0;
               m_addr = data_addr; m_we = data_write_valid;
               m_wdata = data_write; m_wstrb = data_write_byte;
            end else begin
               m_busy = 0; m_gnted = 0; m_owner = 0; m_run = 0;
            end
         end
      end
   end

   // Compare every cycle against the model; also score grant order when tracking.
   always @(negedge clk) begin
      logic e_req, e_resp;
      logic [1:0] got;
      e_req  = m_busy && !m_gnted;
      e_resp = m_busy && m_gnted && mem_rvalid;
      chk("mem_req", mem_req, e_req);
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_wstrb", mem_wstrb, m_wstrb);
      chk("instruction_ack", instruction_ack, e_req && mem_gnt && m_owner == 1);
      chk("data_ack", data_ack, e_req && mem_gnt && m_owner == 2);
      chk("instruction_ready", instruction_ready, e_resp && m_owner == 1);
      chk("data_ready", data_ready, e_resp && m_owner == 2);
      chk("instruction_read", instruction_read, (e_resp && m_owner == 1) ? mem_rdata : m_iread);
      chk("data_read", data_read, (e_resp && m_owner == 2) ? mem_rdata : m_dread);
      if (track && (instruction_ack || data_ack)) begin
         got = {data_ack, instruction_ack};
         if (exp_q.size() == 0) begin
            chk("grant_extra", 32'(got), 32'd0);
         end else begin
            chk("grant_order", 32'(got), 32'(exp_q.pop_front()));
         end
      end
   end

   // Driver helpers: inputs change 1 time unit after the rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Stimulus
   initial begin
      // Reset state
      sample();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_iread", instruction_read, 0);
      next_cycle();
      reset = 1'b0;
      next_cycle();

      // 1: single fetch
      instruction_valid = 1; instruction_addr = 32'h0001_0000;
      sample(); chk("t1_c0_req", mem_req, 0);
      next_cycle(); mem_gnt = 1;
      sample();
      chk("t1_c1_req", mem_req, 1);
      chk("t1_c1_iack", instruction_ack, 1);
      chk("t1_c1_we", mem_we, 0);
      chk("t1_c1_addr", mem_addr, 32'h0001_0000);
      next_cycle(); instruction_valid = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
      sample();
      chk("t1_c2_req", mem_req, 0);
      chk("t1_c2_irdy", instruction_ready, 1);
      chk("t1_c2_iread", instruction_read, 32'h0000_0013);
      next_cycle(); mem_rvalid = 0; mem_rdata = 32'h0;
      sample();
      chk("t1_c3_irdy", instruction_ready, 0);
      chk("t1_c3_hold", instruction_read, 32'h0000_0013);

      // 2: store
      next_cycle();
      data_write_valid = 1; data_addr = 32'h0000_2000;
      data_write = 32'hDEAD_BEEF; data_write_byte = 4'b0011;
      next_cycle(); mem_gnt = 1;
      sample();
      chk("t2_we", mem_we, 1);
      chk("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("t2_wstrb", mem_wstrb, 4'b0011);
      chk("t2_dack", data_ack, 1);
      next_cycle(); data_write_valid = 0; mem_gnt = 0; mem_rvalid = 1;
      sample(); chk("t2_drdy", data_ready, 1);
      next_cycle(); mem_rvalid = 0;

      // 3: contention, fetch and data valid continuously
      next_cycle();
      exp_q.push_back(2'd2); exp_q.push_back(2'd2); exp_q.push_back(2'd1);
      exp_q.push_back(2'd2); exp_q.push_back(2'd2); exp_q.push_back(2'd1);
      exp_q.push_back(2'd2);
      track = 1'b1;
      instruction_valid = 1; instruction_addr = 32'h0000_0100;
      data_read_valid = 1; data_addr = 32'h0000_8000;
      data_write = 32'h0; data_write_byte = 4'h0;
      for (int k = 0; k < 6; k++) begin
         next_cycle(); mem_gnt = 1; mem_rvalid = 0;
         next_cycle(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'(k + 1);
      end
      next_cycle(); instruction_valid = 0; data_read_valid = 0; mem_rvalid = 0; mem_gnt = 1;
      next_cycle(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h77;
      next_cycle(); mem_rvalid = 0;
      sample();
      chk("t3_grants_left", exp_q.size(), 0);
      track = 1'b0;

      // 4: stalled memory
      next_cycle(); data_read_valid = 1; data_addr = 32'h0000_3000;
      for (int k = 0; k < 5; k++) begin
         next_cycle(); mem_gnt = 0;
         sample();
         chk("t4_stall_req", mem_req, 1);
         chk("t4_stall_addr", mem_addr, 32'h0000_3000);
         chk("t4_stall_dack", data_ack, 0);
      end
      next_cycle(); mem_gnt = 1;
      sample(); chk("t4_dack", data_ack, 1);
      next_cycle(); data_read_valid = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
      sample();
      chk("t4_drdy", data_ready, 1);
      chk("t4_dread", data_read, 32'hCAFE_F00D);
      next_cycle(); mem_rvalid = 0; mem_rdata = 32'h0;
      sample(); chk("t4_hold", data_read, 32'hCAFE_F00D);

      // 5: read and write both valid, then a spurious response in IDLE
      next_cycle();
      data_read_valid = 1; data_write_valid = 1; data_addr = 32'h0000_4000;
      data_write = 32'h1234_5678; data_write_byte = 4'hF;
      next_cycle(); mem_gnt = 1;
      sample(); chk("t5_we", mem_we, 1); chk("t5_dack", data_ack, 1);
      next_cycle(); data_read_valid = 0; data_write_valid = 0; mem_gnt = 0; mem_rvalid = 1;
      next_cycle(); mem_rvalid = 1; mem_rdata = 32'h0000_0BAD;
      sample();
      chk("t5_spur_drdy", data_ready, 0);
      chk("t5_spur_irdy", instruction_ready, 0);
      chk("t5_spur_dread", data_read, 32'h0);
      next_cycle(); mem_rvalid = 0; mem_rdata = 32'h0;

      // 6: reset while waiting for the response
      next_cycle(); data_read_valid = 1; data_addr = 32'h0000_5000;
      data_write = 32'h0; data_write_byte = 4'h0;
      next_cycle(); mem_gnt = 1;
      next_cycle(); mem_gnt = 0; data_read_valid = 0;
      #2 reset = 1'b1;
      #1;
      chk("t6_rst_req", mem_req, 0);
      chk("t6_rst_addr", mem_addr, 0);
      chk("t6_rst_iread", instruction_read, 0);
      chk("t6_rst_ack", {instruction_ack, data_ack, instruction_ready, data_ready}, 0);
      next_cycle();
      #2 reset = 1'b0; mem_rvalid = 1; mem_rdata = 32'h00BA_DBAD;
      sample();
      chk("t6_stale_drdy", data_ready, 0);
      chk("t6_stale_dread", data_read, 0);
      next_cycle(); mem_rvalid = 0; instruction_valid = 1; instruction_addr = 32'h0000_6000;
      next_cycle(); mem_gnt = 1;
      sample(); chk("t6_iack", instruction_ack, 1); chk("t6_addr", mem_addr, 32'h0000_6000);
      next_cycle(); instruction_valid = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0010_0093;
      sample(); chk("t6_irdy", instruction_ready, 1); chk("t6_iread", instruction_read, 32'h0010_0093);
      next_cycle(); mem_rvalid = 0;
      repeat (3) next_cycle();

      // Final report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the core's instruction-fetch requester and its data load/store requester.
- Sits between the riscv32 core and the unified memory inside top.
- Data requests win by default; a starvation limit forces an instruction grant after too many consecutive data grants.
- Sequences each transaction as request, grant (ack), then response (ready).

Parameters:
- XLEN, 32, address/data width.
- STARVE_LIMIT, 2, consecutive data grants allowed while an instruction request waits (≥1).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- instruction_valid  input  1  fetch request pending
- instruction_addr  input  XLEN  fetch address
- instruction_ack  output  1  fetch request accepted by memory this cycle
- instruction_ready  output  1  instruction_read valid this cycle
- instruction_read  output  XLEN  fetched word
- data_read_valid  input  1  load request
- data_write_valid  input  1  store request
- data_addr  input  XLEN  load/store address
- data_write  input  XLEN  store data
- data_write_byte  input  XLEN/8  store byte enables
- data_ack  output  1  data request accepted this cycle
- data_ready  output  1  load data valid / store complete this cycle
- data_read  output  XLEN  load data
- mem_req  output  1  request to memory
- mem_we  output  1  write request
- mem_addr  output  XLEN  memory address
- mem_wdata  output  XLEN  write data
- mem_wstrb  output  XLEN/8  byte strobes
- mem_gnt  input  1  memory accepts request (qualified by mem_req)
- mem_rvalid  input  1  memory response / write completion
- mem_rdata  input  XLEN  memory read data

Behaviour:
- One clock domain, clk. reset is asynchronous and active-high. While reset is high:
  - state=IDLE, owner=NONE, starve_cnt=0.
  - All outputs 0, including mem_addr, mem_wdata, mem_wstrb, instruction_read and data_read.
- State IDLE
  - Arbitrate on the current-cycle valids.
  - Data request: data_read_valid or data_write_valid.
  - Winner is data unless instruction_valid=1 and starve_cnt==STARVE_LIMIT; then instruction wins.
  - If there is a winner: register addr, we, wdata and wstrb into the mem_* output registers; set owner; go to REQ.
  - Instruction requests: mem_we=0, mem_wstrb=0.
- State REQ
  - mem_req=1; fields held stable.
  - On mem_gnt=1: pulse the owner's ack for this single cycle; drop mem_req next cycle; go to WAIT.
- State WAIT
  - mem_req=0.
  - On mem_rvalid=1: pulse the owner's ready this cycle; the owner's read output = mem_rdata combinationally; otherwise hold last value.
  - In the same cycle, arbitrate exactly as in IDLE. A winner goes straight to REQ; no winner goes to IDLE.
  - A requester's valid seen after its own ack is a new request.
- Starvation counter
  - Data grant while instruction_valid=1: starve_cnt+1, saturating at STARVE_LIMIT.
  - Instruction grant, or arbitration with instruction_valid=0: reset to 0.
- Latency: valid sampled at cycle 0 → mem_req at cycle 1 → ack in the first cycle with mem_gnt (earliest cycle 1) → ready in the mem_rvalid cycle (earliest cycle 2).
- Requester contract: hold valid and all fields until ack. The arbiter latches them at arbitration, so changes after that cycle are ignored.
- data_read_valid and data_write_valid both 1: treated as a write.
- Ignored inputs:
  - mem_gnt while mem_req=0.
  - mem_rvalid in IDLE or REQ (covers responses in flight across reset).
  - Ack/ready are never asserted to a non-owner.
- Reset mid-transaction: immediate abort. The requester must reissue.
- Only one transaction is ever outstanding.

Decomposition:
- Package riscv_mem_pkg:
  - XLEN default constant.
  - typedef enum arb_state_t {IDLE, REQ, WAIT}.
  - typedef enum owner_t {OWN_NONE, OWN_INSTR, OWN_DATA}.
  - Struct mem_req_t {addr, we, wdata, wstrb}.
- One sub-module, mem_arb_pick: combinational winner selection from the valids and starve_cnt, plus the next-starve_cnt value. Reused by the IDLE and WAIT arbitration paths.

Test Plan:
1. Single fetch:
   - Stimulus: instruction_valid, addr=0x00010000, memory answers gnt at cycle 1 and rvalid at cycle 2 with 0x00000013.
   - Required: mem_req cycles 1–1; instruction_ack at cycle 1; instruction_ready at cycle 2 with instruction_read=0x00000013; mem_we=0.
2. Store:
   - Stimulus: data_write_valid, addr=0x2000, data=0xDEADBEEF, byte=4'b0011.
   - Required: mem_we=1, mem_wdata=0xDEADBEEF, mem_wstrb=0011; data_ack on gnt; data_ready on rvalid.
3. Contention with STARVE_LIMIT=2:
   - Stimulus: instruction and data valid continuously.
   - Required: grant order D, D, I, D, D, I; starve_cnt returns to 0 after each I grant.
4. Stalled memory:
   - Stimulus: mem_gnt held low 5 cycles.
   - Required: mem_req and fields stable for all 5 cycles; no ack; ack in the gnt cycle.
5. Both data_read_valid and data_write_valid high:
   - Required: mem_we=1. A spurious mem_rvalid in IDLE produces no ready.
6. Reset asserted in WAIT:
   - Required: all outputs 0 asynchronously.
   - The stale mem_rvalid after reset release produces no ready.
   - A new request then completes normally.
